frame_scanner: RTL and testbench

Parametrised framebuffer read-out engine that sweeps a synchronous display RAM from address 0 to DEPTH-1 and presents each word to the downstream display driver over a valid/ready handshake. It sits between the framebuffer RAM and the pixel/segment driver. It adds start/stop control, single-shot or continuous loop mode, backpressure, and configurable data/address width and depth.

---
 rtl/frame_scanner_if.sv | 29 ++
 rtl/frame_scanner.sv | 105 ++++++++++
 tb/tb_frame_scanner.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scanner_if.sv
// frame_scanner_if: RAM read port and downstream word handshake of the frame scanner.
interface frame_scanner_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          start;
    logic          loop;
    logic          stop;
    logic [DW-1:0] ram_dout;
    logic          ram_clk;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          frame_start;
    logic          done;

    modport master (
        input  start, loop, stop, ram_dout, dout_ready,
        output ram_clk, ram_we, ram_addr, dout, dout_valid, busy, frame_start, done
    );

    modport slave (
        output start, loop, stop, ram_dout, dout_ready,
        input  ram_clk, ram_we, ram_addr, dout, dout_valid, busy, frame_start, done
    );
endinterface

// File: rtl/frame_scanner.sv
// frame_scanner: sweeps a display RAM from 0 to DEPTH-1 and streams each word over valid/ready,
// with single-shot or looping frames and a frame-boundary stop request.
module frame_scanner #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 128
) (
    input logic             clk,
    input logic             rst,
    frame_scanner_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LATCH, OUT} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          ram_clk_q, ram_clk_d;
    logic          busy_q, busy_d;
    logic          frame_start_q, frame_start_d;
    logic          done_q, done_d;
    logic          stop_req_q, stop_req_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        ram_clk_d     = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        stop_req_d    = stop_req_q || (state_q != IDLE && bus.stop);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d       = FETCH;
                addr_d        = '0;
                ram_clk_d     = 1'b1;
                frame_start_d = 1'b1;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                dout_d       = bus.ram_dout;
                dout_valid_d = 1'b1;
                state_d      = OUT;
            end
            OUT: if (dout_valid_q && bus.dout_ready) begin
                dout_valid_d = 1'b0;
                if (addr_q != LAST) begin
                    addr_d    = addr_q + 1'b1;
                    ram_clk_d = 1'b1;
                    state_d   = FETCH;
                end else begin
                    done_d = 1'b1;
                    // loop is only honoured here, at the last handshake of the frame
                    if (bus.loop && !stop_req_q) begin
                        addr_d        = '0;
                        ram_clk_d     = 1'b1;
                        frame_start_d = 1'b1;
                        state_d       = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        stop_req_d = (state_d == IDLE) ? 1'b0 : stop_req_d;
        busy_d     = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            ram_clk_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            stop_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            ram_clk_q     <= ram_clk_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            stop_req_q    <= stop_req_d;
        end
    end

    assign bus.ram_clk     = ram_clk_q;
    assign bus.ram_we      = 1'b0;
    assign bus.ram_addr    = addr_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: three scanner configurations against a word-stream reference model plus directed timing, backpressure, loop/stop and reset steps.
module tb_frame_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  frame_scanner_if #(.DW(8),  .AW(8)) ia ();
  frame_scanner_if #(.DW(8),  .AW(8)) ib ();
  frame_scanner_if #(.DW(16), .AW(4)) ic ();
  frame_scanner #(.DW(8),  .AW(8), .DEPTH(4))  u_a (.clk(clk), .rst(rst), .bus(ia));
  frame_scanner #(.DW(8),  .AW(8), .DEPTH(1))  u_b (.clk(clk), .rst(rst), .bus(ib));
  frame_scanner #(.DW(16), .AW(4), .DEPTH(16)) u_c (.clk(clk), .rst(rst), .bus(ic));
  logic [15:0] mem [3][16];
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    if (o !== e) begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask
  always @(posedge clk) begin
    if (ia.ram_clk) ia.ram_dout <= mem[0][4'(ia.ram_addr)][7:0];
    if (ib.ram_clk) ib.ram_dout <= mem[1][4'(ib.ram_addr)][7:0];
    if (ic.ram_clk) ic.ram_dout <= mem[2][ic.ram_addr];
  end
  int exp_idx [3];
  int gap [3];
  int words [3] = '{0, 0, 0};
  int dones [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  logic hs_last [3];
  logic stall [3];
  logic [15:0] pdout [3];
  int hs_q [$];
  task automatic mon(input int k, input int depth, input logic [15:0] d, input logic v, r, rc, we,
                     input logic [7:0] a, input logic fs, dn);
    if (!rst) begin
      exp_idx[k] = 0;
      hs_last[k] = 1'b0;
      stall[k] = 1'b0;
      gap[k] = 2;
      return;
    end
    chk("ram_we", we, 1'b0);
    chk("done", dn, hs_last[k]);
    chk("frame_start", fs, rc && exp_idx[k] == 0);
    if (stall[k]) begin
      chk("hold_valid", v, 1'b1);
      chk("hold_dout", d, pdout[k]);
    end
    if (v && !r) chk("stall_ram_clk", rc, 1'b0);
    if (rc) begin
      chk("ram_clk_gap", gap[k] >= 2, 1'b1);
      chk("fetch_addr", int'(a), exp_idx[k]);
      gap[k] = 0;
    end else begin
      gap[k]++;
    end
    if (dn) begin
      dones[k]++;
      done_cyc[k] = cyc;
    end
    hs_last[k] = 1'b0;
    if (v && r) begin
      chk("word", d, mem[k][exp_idx[k]]);
      chk("word_addr", int'(a), exp_idx[k]);
      words[k]++;
      if (k == 0) hs_q.push_back(cyc);
      if (exp_idx[k] == depth - 1) begin
        hs_last[k] = 1'b1;
        exp_idx[k] = 0;
      end else begin
        exp_idx[k]++;
      end
    end
    stall[k] = v && !r;
    pdout[k] = d;
  endtask
  always @(negedge clk) begin
    mon(0, 4, 16'(ia.dout), ia.dout_valid, ia.dout_ready, ia.ram_clk, ia.ram_we, ia.ram_addr,
        ia.frame_start, ia.done);
    mon(1, 1, 16'(ib.dout), ib.dout_valid, ib.dout_ready, ib.ram_clk, ib.ram_we, ib.ram_addr,
        ib.frame_start, ib.done);
    mon(2, 16, ic.dout, ic.dout_valid, ic.dout_ready, ic.ram_clk, ic.ram_we, 8'(ic.ram_addr),
        ic.frame_start, ic.done);
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int k, input int bound, input bit rnd);
    int n0 = dones[k];
    int c = 0;
    while (dones[k] == n0 && c < bound) begin
      if (rnd) begin
        case (k)
          0: ia.dout_ready = 1'($urandom);
          1: ib.dout_ready = 1'($urandom);
          default: ic.dout_ready = 1'($urandom);
        endcase
      end
      step(1);
      c++;
    end
    chk("done_timeout", dones[k] != n0, 1'b1);
  endtask
  task automatic wait_word_a(input int a);
    int c = 0;
    while (!(ia.dout_valid && int'(ia.ram_addr) == a) && c < 100) begin
      step(1);
      c++;
    end
    chk("word_timeout", ia.dout_valid && int'(ia.ram_addr) == a, 1'b1);
  endtask
  task automatic chk_rst();
    chk("rst_a_addr", ia.ram_addr, 8'd0);
    chk("rst_a_ram_clk", ia.ram_clk, 1'b0);
    chk("rst_a_ram_we", ia.ram_we, 1'b0);
    chk("rst_a_dout", ia.dout, 8'd0);
    chk("rst_a_valid", ia.dout_valid, 1'b0);
    chk("rst_a_busy", ia.busy, 1'b0);
    chk("rst_a_done", ia.done, 1'b0);
    chk("rst_a_fs", ia.frame_start, 1'b0);
    chk("rst_b_busy", ib.busy, 1'b0);
    chk("rst_b_valid", ib.dout_valid, 1'b0);
    chk("rst_c_busy", ic.busy, 1'b0);
    chk("rst_c_addr", ic.ram_addr, 4'd0);
    chk("rst_c_dout", ic.dout, 16'd0);
  endtask
  initial begin
    int c0, d1, n0, hb;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        mem[k][i] = (k < 2) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    {ia.start, ia.loop, ia.stop} = '0;
    {ib.start, ib.loop, ib.stop} = '0;
    {ic.start, ic.loop, ic.stop} = '0;
    ia.dout_ready = 1'b1;
    ib.dout_ready = 1'b1;
    ic.dout_ready = 1'b1;
    #2 rst = 1'b0;
    step(2);
    chk_rst();
    rst = 1'b1;
    step(2);
    hb = hs_q.size();
    n0 = dones[0];
    c0 = cyc;
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    chk("t1_fs", ia.frame_start, 1'b1);
    chk("t1_ram_clk", ia.ram_clk, 1'b1);
    chk("t1_busy", ia.busy, 1'b1);
    step(1);
    chk("t2_ram_clk", ia.ram_clk, 1'b0);
    chk("t2_valid", ia.dout_valid, 1'b0);
    step(1);
    chk("t3_valid", ia.dout_valid, 1'b1);
    wait_done(0, 50, 0);
    chk("frame_len", done_cyc[0] - c0, 13);
    chk("hs_count", hs_q.size() - hb, 4);
    for (int i = 0; i < 4 && hb + i < hs_q.size(); i++)
      chk("hs_cycle", hs_q[hb + i] - c0, 3 * (i + 1));
    step(5);
    chk("single_dones", dones[0] - n0, 1);
    chk("single_busy", ia.busy, 1'b0);
    chk("single_addr", ia.ram_addr, 8'd3);
    c0 = cyc;
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_word_a(1);
    ia.dout_ready = 1'b0;
    step(5);
    ia.dout_ready = 1'b1;
    wait_done(0, 60, 0);
    chk("bp_frame_len", done_cyc[0] - c0, 18);
    step(3);
    n0 = dones[0];
    ia.loop = 1'b1;
    c0 = cyc;
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_done(0, 50, 0);
    d1 = done_cyc[0];
    chk("loop_f1_len", d1 - c0, 13);
    wait_done(0, 50, 0);
    chk("loop_f2_gap", done_cyc[0] - d1, 12);
    d1 = done_cyc[0];
    wait_word_a(1);
    ia.stop = 1'b1;
    step(1);
    ia.stop = 1'b0;
    wait_done(0, 50, 0);
    chk("loop_f3_gap", done_cyc[0] - d1, 12);
    step(10);
    chk("loop_frames", dones[0] - n0, 3);
    chk("loop_idle", ia.busy, 1'b0);
    ia.loop = 1'b0;
    n0 = dones[0];
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_word_a(2);
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_done(0, 50, 0);
    step(8);
    chk("busy_start_frames", dones[0] - n0, 1);
    chk("busy_start_idle", ia.busy, 1'b0);
    ia.stop = 1'b1;
    step(1);
    ia.stop = 1'b0;
    step(3);
    chk("idle_stop_busy", ia.busy, 1'b0);
    chk("idle_stop_addr", ia.ram_addr, 8'd3);
    n0 = dones[0];
    ia.loop = 1'b1;
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_done(0, 50, 0);
    wait_done(0, 50, 0);
    ia.stop = 1'b1;
    step(1);
    ia.stop = 1'b0;
    wait_done(0, 50, 0);
    ia.loop = 1'b0;
    step(6);
    chk("idle_stop_frames", dones[0] - n0, 3);
    chk("idle_stop_end", ia.busy, 1'b0);
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_word_a(2);
    n0 = dones[0];
    rst = 1'b0;
    #1;
    chk_rst();
    step(1);
    rst = 1'b1;
    step(3);
    chk("rst_no_done", dones[0] - n0, 0);
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    chk("rst_restart_addr", ia.ram_addr, 8'd0);
    chk("rst_restart_fs", ia.frame_start, 1'b1);
    wait_done(0, 50, 0);
    chk("rst_restart_end", ia.ram_addr, 8'd3);
    n0 = dones[1];
    ib.loop = 1'b1;
    ib.start = 1'b1;
    step(1);
    ib.start = 1'b0;
    wait_done(1, 20, 0);
    d1 = done_cyc[1];
    wait_done(1, 20, 0);
    chk("d1_gap2", done_cyc[1] - d1, 3);
    d1 = done_cyc[1];
    ib.stop = 1'b1;
    step(1);
    ib.stop = 1'b0;
    wait_done(1, 20, 0);
    chk("d1_gap3", done_cyc[1] - d1, 3);
    step(6);
    chk("d1_frames", dones[1] - n0, 3);
    chk("d1_busy", ib.busy, 1'b0);
    chk("d1_addr", ib.ram_addr, 8'd0);
    ib.loop = 1'b0;
    n0 = words[2];
    ic.start = 1'b1;
    step(1);
    ic.start = 1'b0;
    wait_done(2, 400, 1);
    ic.dout_ready = 1'b1;
    step(2);
    chk("w16_words", words[2] - n0, 16);
    chk("w16_addr", ic.ram_addr, 4'd15);
    chk("w16_busy", ic.busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
